// File: rtl/dwc_and_pipe_if.sv
// Operand/result bus of the DwC AND datapath: operands in, copy-0 result out.
interface dwc_and_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] port_in_0;
   logic [WIDTH-1:0] port_in_1;
   logic             port_in_valid;
   logic [WIDTH-1:0] port_out;
   logic             port_out_valid;

   modport master (
      output port_in_0, port_in_1, port_in_valid,
      input  port_out, port_out_valid
   );

   modport slave (
      input  port_in_0, port_in_1, port_in_valid,
      output port_out, port_out_valid
   );
endinterface

// File: rtl/dwc_and_pipe.sv
// Duplication-with-comparison AND pipeline: two independent DEPTH-stage copies compared at the
// last stage, with sticky error flag, first-mismatch syndrome and saturating mismatch counter.
module dwc_and_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   dwc_and_pipe_if.slave    bus,
   input  logic             port_cmp_en,
   input  logic             port_err_clear,
   output logic             port_error,
   output logic             port_err_sticky,
   output logic [WIDTH-1:0] port_err_synd,
   output logic [CNT_W-1:0] port_err_count
);
   logic [WIDTH-1:0] c0_dat_q [DEPTH];
   logic [WIDTH-1:0] c0_dat_d [DEPTH];
   logic             c0_vld_q [DEPTH];
   logic             c0_vld_d [DEPTH];
   logic [WIDTH-1:0] c1_dat_q [DEPTH];
   logic [WIDTH-1:0] c1_dat_d [DEPTH];
   logic             c1_vld_q [DEPTH];
   logic             c1_vld_d [DEPTH];

   logic [WIDTH-1:0] c0_dat_last, c1_dat_last;
   logic             c0_vld_last, c1_vld_last;
   logic             mis;
   logic [WIDTH-1:0] diff;

   logic             sticky_q, sticky_d;
   logic [WIDTH-1:0] synd_q, synd_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Each copy has its own AND gate and its own shift chain; nothing is shared.
   always_comb begin
      c0_dat_d[0] = bus.port_in_0 & bus.port_in_1;
      c0_vld_d[0] = bus.port_in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         c0_dat_d[i] = c0_dat_q[i-1];
         c0_vld_d[i] = c0_vld_q[i-1];
      end
   end

   always_comb begin
      c1_dat_d[0] = bus.port_in_0 & bus.port_in_1;
      c1_vld_d[0] = bus.port_in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         c1_dat_d[i] = c1_dat_q[i-1];
         c1_vld_d[i] = c1_vld_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            c0_dat_q[i] <= '0;
            c0_vld_q[i] <= 1'b0;
         end
      end else begin
         c0_dat_q <= c0_dat_d;
         c0_vld_q <= c0_vld_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            c1_dat_q[i] <= '0;
            c1_vld_q[i] <= 1'b0;
         end
      end else begin
         c1_dat_q <= c1_dat_d;
         c1_vld_q <= c1_vld_d;
      end
   end

   assign c0_dat_last = c0_dat_q[DEPTH-1];
   assign c0_vld_last = c0_vld_q[DEPTH-1];
   assign c1_dat_last = c1_dat_q[DEPTH-1];
   assign c1_vld_last = c1_vld_q[DEPTH-1];

   // A valid-bit disagreement counts even when both data words are equal.
   assign mis  = port_cmp_en & (c0_vld_last | c1_vld_last) &
                 ((c0_vld_last != c1_vld_last) | (c0_dat_last != c1_dat_last));
   assign diff = c0_dat_last ^ c1_dat_last;

   always_comb begin
      sticky_d = sticky_q;
      synd_d   = synd_q;
      count_d  = count_q;
      if (port_err_clear) begin
         sticky_d   = mis;
         synd_d     = mis ? diff : '0;
         count_d    = '0;
         count_d[0] = mis;
      end else if (mis) begin
         sticky_d = 1'b1;
         if (!sticky_q) synd_d = diff;
         if (count_q != '1) count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 1'b0;
         synd_q   <= '0;
         count_q  <= '0;
      end else begin
         sticky_q <= sticky_d;
         synd_q   <= synd_d;
         count_q  <= count_d;
      end
   end

   assign bus.port_out       = c0_dat_last;
   assign bus.port_out_valid = c0_vld_last;
   assign port_error         = mis;
   assign port_err_sticky    = sticky_q;
   assign port_err_synd      = synd_q;
   assign port_err_count     = count_q;
endmodule

// File: tb/tb_dwc_and_pipe.sv
// Randomised scoreboard bench for dwc_and_pipe with copy-1 last-stage fault injection.
module tb_dwc_and_pipe;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   localparam int CNT_W = 4;
   localparam int MAXC  = 1024;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmp_en = 1'b1;
   logic err_clr = 1'b0;
   logic port_error, port_err_sticky;
   logic [WIDTH-1:0] port_err_synd;
   logic [CNT_W-1:0] port_err_count;

   dwc_and_pipe_if #(.WIDTH(WIDTH)) bus ();

   dwc_and_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .port_cmp_en(cmp_en), .port_err_clear(err_clr),
      .port_error(port_error), .port_err_sticky(port_err_sticky),
      .port_err_synd(port_err_synd), .port_err_count(port_err_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [WIDTH-1:0] d; int due; } sb_t;
   sb_t sbq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference: what was presented to the block in each cycle.
   logic             hist_v [MAXC];
   logic [WIDTH-1:0] hist_d [MAXC];

   // Reference error state and injected copy-1 last-stage values.
   logic             e_sticky = 1'b0;
   logic [WIDTH-1:0] e_synd = '0;
   int               e_count = 0;
   logic             exp_m = 1'b0;
   logic [WIDTH-1:0] exp_x = '0;
   logic             f_en = 1'b0;
   logic             f_v = 1'b0;
   logic [WIDTH-1:0] f_d = '0;
   logic [WIDTH-1:0] last_nz = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [WIDTH:0] last_stage(input int c);
      int k = c - DEPTH;
      if (k < 0 || k >= MAXC) return '0;
      return {hist_v[k], hist_d[k]};
   endfunction

   always @(negedge rst_n) begin
      for (int i = 0; i < MAXC; i++) begin
         hist_v[i] = 1'b0;
         hist_d[i] = '0;
      end
      sbq.delete();
      e_sticky = 1'b0;
      e_synd   = '0;
      e_count  = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         if (cyc < MAXC) begin
            hist_v[cyc] = bus.port_in_valid;
            hist_d[cyc] = bus.port_in_0 & bus.port_in_1;
         end
         if (bus.port_in_valid) sbq.push_back('{d: bus.port_in_0 & bus.port_in_1, due: cyc + DEPTH});
         if (err_clr) begin
            e_sticky = exp_m;
            e_synd   = exp_m ? exp_x : '0;
            e_count  = exp_m ? 1 : 0;
         end else if (exp_m) begin
            if (!e_sticky) e_synd = exp_x;
            e_sticky = 1'b1;
            if (e_count < CMAX) e_count++;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      logic [WIDTH:0]   ls;
      logic             v0, v1;
      logic [WIDTH-1:0] d0, d1;
      sb_t              e;
      ls = last_stage(cyc);
      v0 = ls[WIDTH];
      d0 = ls[WIDTH-1:0];
      v1 = f_en ? f_v : v0;
      d1 = f_en ? f_d : d0;
      exp_m = cmp_en & (v0 | v1) & ((v0 != v1) | (d0 != d1));
      exp_x = d0 ^ d1;
      chk("out_valid", {31'b0, bus.port_out_valid}, {31'b0, v0});
      if (bus.port_out_valid) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_out", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("out_data", {24'b0, bus.port_out}, {24'b0, e.d});
            chk("out_latency", cyc, e.due);
         end
      end
      chk("error", {31'b0, port_error}, {31'b0, exp_m});
      chk("sticky", {31'b0, port_err_sticky}, {31'b0, e_sticky});
      chk("synd", {24'b0, port_err_synd}, {24'b0, e_synd});
      chk("count", {28'b0, port_err_count}, e_count);
   end

   // mode 0: set data bit 0; 1: force valid high; 2: valid high and flip random nonzero bits
   task automatic set_fault(input int mode);
      logic [WIDTH:0] ls;
      ls = last_stage(cyc);
      f_v = ls[WIDTH];
      f_d = ls[WIDTH-1:0];
      case (mode)
         0: f_d = f_d | 8'h01;
         1: f_v = 1'b1;
         default: begin
            last_nz = 8'($urandom_range(1, 255));
            f_v = 1'b1;
            f_d = f_d ^ last_nz;
         end
      endcase
      f_en = 1'b1;
      force dut.c1_dat_last = f_d;
      force dut.c1_vld_last = f_v;
   endtask

   task automatic clr_fault();
      if (f_en) begin
         release dut.c1_dat_last;
         release dut.c1_vld_last;
      end
      f_en = 1'b0;
   endtask

   task automatic step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic v,
                       input int fmode);
      bus.port_in_0 = a;
      bus.port_in_1 = b;
      bus.port_in_valid = v;
      if (fmode >= 0) set_fault(fmode);
      else clr_fault();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_step(input int fmode);
      step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), fmode);
   endtask

   initial begin
      logic [WIDTH-1:0] first_nz;
      logic [WIDTH-1:0] r;
      for (int i = 0; i < MAXC; i++) begin
         hist_v[i] = 1'b0;
         hist_d[i] = '0;
      end
      bus.port_in_0 = '0;
      bus.port_in_1 = '0;
      bus.port_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'b0, bus.port_out_valid}, 32'd0);
      chk("rst_out", {24'b0, bus.port_out}, 32'd0);
      rst_n = 1'b1;

      // Reset/latency: 0xF0 & 0x3C = 0x30 after DEPTH edges
      step(8'hF0, 8'h3C, 1'b1, -1);
      step(8'h00, 8'h00, 1'b0, -1);
      @(negedge clk);
      chk("t1_out", {24'b0, bus.port_out}, 32'h30);
      chk("t1_valid", {31'b0, bus.port_out_valid}, 32'd1);
      chk("t1_count", {28'b0, port_err_count}, 32'd0);
      @(posedge clk);
      #1;

      repeat (30) rnd_step(-1);

      // Data fault on a 0x30 result
      step(8'hF0, 8'h3C, 1'b1, -1);
      step(8'h00, 8'h00, 1'b0, -1);
      step(8'h00, 8'h00, 1'b0, 0);
      clr_fault();
      chk("t2_sticky", {31'b0, port_err_sticky}, 32'd1);
      chk("t2_synd", {24'b0, port_err_synd}, 32'h01);
      chk("t2_count", {28'b0, port_err_count}, 32'd1);

      // Valid fault while copy 0 is idle
      repeat (DEPTH + 1) begin
         r = 8'($urandom);
         step(r, r, 1'b0, -1);
      end
      step(8'h00, 8'h00, 1'b0, 1);
      clr_fault();
      chk("t3_count", {28'b0, port_err_count}, 32'd2);
      chk("t3_synd", {24'b0, port_err_synd}, 32'h01);

      err_clr = 1'b1;
      step(8'h00, 8'h00, 1'b0, -1);
      err_clr = 1'b0;
      chk("clr_count", {28'b0, port_err_count}, 32'd0);
      chk("clr_sticky", {31'b0, port_err_sticky}, 32'd0);

      // Saturation over 20 mismatch cycles
      rnd_step(2);
      first_nz = last_nz;
      repeat (19) rnd_step(2);
      clr_fault();
      chk("t4_count", {28'b0, port_err_count}, CMAX);
      chk("t4_synd_first", {24'b0, port_err_synd}, {24'b0, first_nz});

      // Clear colliding with a mismatch, then a clean clear
      err_clr = 1'b1;
      rnd_step(2);
      clr_fault();
      chk("t5_count", {28'b0, port_err_count}, 32'd1);
      chk("t5_sticky", {31'b0, port_err_sticky}, 32'd1);
      chk("t5_synd", {24'b0, port_err_synd}, {24'b0, last_nz});
      rnd_step(-1);
      err_clr = 1'b0;
      chk("t5b_count", {28'b0, port_err_count}, 32'd0);
      chk("t5b_synd", {24'b0, port_err_synd}, 32'd0);

      // Comparison disabled during a fault
      cmp_en = 1'b0;
      repeat (3) rnd_step(2);
      clr_fault();
      cmp_en = 1'b1;
      chk("t6_count", {28'b0, port_err_count}, 32'd0);

      repeat (10) rnd_step(-1);
      repeat (3) step(8'($urandom), 8'($urandom), 1'b1, -1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'b0, bus.port_out_valid}, 32'd0);
      chk("t6_rst_out", {24'b0, bus.port_out}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (15) step(8'($urandom), 8'($urandom), 1'b1, -1);
      repeat (20) rnd_step(-1);
      repeat (DEPTH + 2) step(8'h00, 8'h00, 1'b0, -1);
      chk("sb_drained", sbq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, got no finish, expected finish");
      $fatal(1);
   end
endmodule
